rf_mp: RTL

Multi-port, parametrised general-purpose register file for the CPU core. It replaces the single-write, dual-read register file and adds:
- `NUM_RD` read ports and `NUM_WR` write ports;
- optional same-cycle write-to-read bypass;
- a per-register pending scoreboard for hazard detection;
- a post-reset clear sequencer, so the storage array needs no reset.

It sits between decode/issue (reads, pending marks) and writeback (writes).

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 58 +++++
 rtl/rf_mp.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the multi-port register file.
package rf_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_NUM_REG    = 32;

    // Clear-sequencer state encoding
    localparam logic [0:0] RF_INIT = 1'b0;
    localparam logic [0:0] RF_RUN  = 1'b1;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard: issue marks, writeback clears, flush, busy lookup.
module rf_scoreboard #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REG    = 32,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned NUM_RD     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_en,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    input  logic                         flush,
    input  logic [NUM_WR-1:0]            wr_act,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    input  logic [NUM_RD-1:0]            rd_fwd,
    output logic [NUM_RD-1:0]            rbusy
);

    localparam logic [ADDR_WIDTH:0] NUM_REG_W = (ADDR_WIDTH+1)'(NUM_REG);

    logic [NUM_REG-1:0] pend_q;
    logic [NUM_REG-1:0] pend_d;

    // Next pending vector: flush, then writeback clears, then issue sets (issue wins)
    always_comb begin
        pend_d = flush ? '0 : pend_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_act[j]) begin
                pend_d[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (issue_en && (issue_addr != '0) && ({1'b0, issue_addr} < NUM_REG_W)) begin
            pend_d[issue_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Pending register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Busy lookup per read port; a forwarded write satisfies the hazard
    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if ({1'b0, raddr[i*ADDR_WIDTH +: ADDR_WIDTH]} < NUM_REG_W) begin
                rbusy[i] = pend_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]] & ~rd_fwd[i];
            end
        end
    end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with optional write bypass, pending scoreboard and
// a post-reset clear sequencer so the storage array itself needs no reset.
module rf_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned NUM_REG    = RF_NUM_REG,
    parameter int unsigned NUM_RD     = 4,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    output logic                         init_done,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic [NUM_WR-1:0]            wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
    input  logic                         issue_en,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    input  logic                         flush
);

    localparam logic [ADDR_WIDTH:0]   NUM_REG_W = (ADDR_WIDTH+1)'(NUM_REG);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = ADDR_WIDTH'(NUM_REG - 1);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_q, clr_d;
    logic                  init_done_d;
    logic                  run;
    logic [NUM_WR-1:0]     wr_act;
    logic [NUM_RD-1:0]     rd_fwd;
    logic [DATA_WIDTH-1:0] mem [NUM_REG];

    assign run = (state_q == RF_RUN);

    // Next-state logic for the clear sequencer
    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        init_done_d = init_done;
        case (state_q)
            RF_INIT: begin
                clr_d = clr_q + ADDR_WIDTH'(1);
                if (clr_q == CLR_LAST) begin
                    state_d     = RF_RUN;
                    init_done_d = 1'b1;
                end
            end
            RF_RUN: begin
                init_done_d = 1'b1;
            end
            default: begin
                state_d     = RF_INIT;
                init_done_d = 1'b0;
            end
        endcase
    end

    // Sequencer state registers; clearing starts at entry 1 (entry 0 is never stored)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RF_INIT;
            clr_q     <= ADDR_WIDTH'(1);
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            init_done <= init_done_d;
        end
    end

    // A write is live only in RUN, to a nonzero in-range address
    always_comb begin
        wr_act = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_act[j] = run && wen[j]
                        && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                        && ({1'b0, waddr[j*ADDR_WIDTH +: ADDR_WIDTH]} < NUM_REG_W);
        end
    end

    // Storage: clear during INIT, otherwise write ports in ascending order so the highest index wins
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_q] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_act[j]) begin
                    mem[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Read muxes with optional same-cycle forwarding (highest matching write port wins)
    always_comb begin
        rdata  = '0;
        rd_fwd = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (run && (raddr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                    && ({1'b0, raddr[i*ADDR_WIDTH +: ADDR_WIDTH]} < NUM_REG_W)) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (wr_act[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH]
                                          == raddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                            rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
                            rd_fwd[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Hazard scoreboard; issue and flush only act in RUN
    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REG    (NUM_REG),
        .NUM_WR     (NUM_WR),
        .NUM_RD     (NUM_RD)
    ) u_sb (
        .clk        (clk),
        .rst_n      (resetn),
        .issue_en   (issue_en & run),
        .issue_addr (issue_addr),
        .flush      (flush & run),
        .wr_act     (wr_act),
        .waddr      (waddr),
        .raddr      (raddr),
        .rd_fwd     (rd_fwd),
        .rbusy      (rbusy)
    );

endmodule
